// File: rtl/tl_initiator.sv
// TileLink-UL/UH initiator: turns one command plus its write-data stream into
// A-channel beats and forwards the matching D-channel beats as responses.
module tl_initiator #(
    parameter int TL_RS     = 4,
    parameter int TL_AW     = 16,
    parameter int SOURCE_ID = 0,
    parameter int MAX_SIZE  = 6
) (
    input  logic             tlm_clock_i,
    input  logic             tlm_reset_i,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_opcode,
    input  logic [2:0]       cmd_param,
    input  logic [3:0]       cmd_size,
    input  logic [TL_AW-1:0] cmd_address,

    input  logic             wd_valid,
    output logic             wd_ready,
    input  logic [31:0]      wd_data,
    input  logic [3:0]       wd_mask,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_last,
    output logic             rsp_error,

    output logic             busy,
    output logic             stray_o,

    output logic [2:0]       tlm_a_opcode,
    output logic [2:0]       tlm_a_param,
    output logic [3:0]       tlm_a_size,
    output logic [TL_RS-1:0] tlm_a_source,
    output logic [TL_AW-1:0] tlm_a_address,
    output logic [3:0]       tlm_a_mask,
    output logic [31:0]      tlm_a_data,
    output logic             tlm_a_corrupt,
    output logic             tlm_a_valid,
    input  logic             tlm_a_ready,

    input  logic [2:0]       tlm_d_opcode,
    input  logic [1:0]       tlm_d_param,
    input  logic [3:0]       tlm_d_size,
    input  logic [TL_RS-1:0] tlm_d_source,
    input  logic             tlm_d_denied,
    input  logic [31:0]      tlm_d_data,
    input  logic             tlm_d_corrupt,
    input  logic             tlm_d_valid,
    output logic             tlm_d_ready
);

    // Wide enough to hold the beat count of the largest legal burst.
    localparam int CNT_W = (MAX_SIZE > 6) ? MAX_SIZE - 1 : 5;
    localparam logic [3:0]       MAX_SIZE_L = 4'(MAX_SIZE);
    localparam logic [TL_RS-1:0] SRC_ID     = TL_RS'(SOURCE_ID);

    localparam logic [2:0] OP_PUT_PARTIAL    = 3'd1;
    localparam logic [2:0] OP_GET            = 3'd4;
    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {
        IDLE,
        A_SEND,
        A_DONE_D_WAIT,
        ERR_RSP
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         opcode_q, opcode_d;
    logic [2:0]         param_q, param_d;
    logic [3:0]         size_q, size_d;
    logic [TL_AW-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]   a_cnt_q, a_cnt_d;
    logic [CNT_W-1:0]   d_cnt_q, d_cnt_d;
    logic               stray_q, stray_d;

    logic               misaligned;
    logic               cmd_illegal;
    logic               cmd_is_put;
    logic [CNT_W-1:0]   cmd_beats;
    logic [3:0]         size_mask;
    logic               is_put;
    logic [2:0]         d_opcode_exp;
    logic               a_fire;

    // D fields carried by the protocol but not needed by this bridge.
    logic               unused_d_fields;
    assign unused_d_fields = ^{tlm_d_param, tlm_d_size};

    always_comb begin
        unique case (cmd_size)
            4'd0:    misaligned = 1'b0;
            4'd1:    misaligned = cmd_address[0];
            default: misaligned = |cmd_address[1:0];
        endcase
        cmd_illegal = (cmd_opcode > OP_GET) || (cmd_size > MAX_SIZE_L) || misaligned;
        cmd_is_put  = (cmd_opcode[2:1] == 2'b00);
        if (cmd_size <= 4'd2) begin
            cmd_beats = CNT_W'(1);
        end else begin
            cmd_beats = CNT_W'(1) << (cmd_size - 4'd2);
        end
    end

    always_comb begin
        unique case (size_q)
            4'd0:    size_mask = 4'b0001 << addr_q[1:0];
            4'd1:    size_mask = addr_q[1] ? 4'b1100 : 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        is_put       = (opcode_q[2:1] == 2'b00);
        d_opcode_exp = is_put ? D_ACCESS_ACK : D_ACCESS_ACK_DATA;
    end

    assign tlm_a_opcode  = opcode_q;
    assign tlm_a_param   = param_q;
    assign tlm_a_size    = size_q;
    assign tlm_a_source  = SRC_ID;
    assign tlm_a_address = addr_q;
    assign tlm_a_corrupt = 1'b0;
    assign busy          = (state_q != IDLE);
    assign stray_o       = stray_q;

    // NOTE: every output and next-state value gets a default first so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        param_d     = param_q;
        size_d      = size_q;
        addr_d      = addr_q;
        a_cnt_d     = a_cnt_q;
        d_cnt_d     = d_cnt_q;
        stray_d     = 1'b0;
        cmd_ready   = 1'b0;
        wd_ready    = 1'b0;
        tlm_a_valid = 1'b0;
        tlm_a_data  = '0;
        tlm_a_mask  = '0;
        tlm_d_ready = 1'b0;
        rsp_valid   = 1'b0;
        rsp_data    = '0;
        rsp_last    = 1'b0;
        rsp_error   = 1'b0;
        a_fire      = 1'b0;

        unique case (state_q)
            IDLE: begin
                cmd_ready   = 1'b1;
                tlm_d_ready = 1'b1;
                stray_d     = tlm_d_valid;
                if (cmd_valid) begin
                    opcode_d = cmd_opcode;
                    param_d  = cmd_param;
                    size_d   = cmd_size;
                    addr_d   = cmd_address;
                    if (cmd_illegal) begin
                        a_cnt_d = '0;
                        d_cnt_d = '0;
                        state_d = ERR_RSP;
                    end else begin
                        a_cnt_d = (cmd_opcode == OP_GET) ? CNT_W'(1) : cmd_beats;
                        d_cnt_d = cmd_is_put ? CNT_W'(1) : cmd_beats;
                        state_d = A_SEND;
                    end
                end
            end

            A_SEND, A_DONE_D_WAIT: begin
                if (state_q == A_SEND) begin
                    if (opcode_q == OP_GET) begin
                        tlm_a_valid = 1'b1;
                        tlm_a_mask  = size_mask;
                    end else begin
                        tlm_a_valid = wd_valid;
                        wd_ready    = tlm_a_ready;
                        tlm_a_data  = wd_data;
                        tlm_a_mask  = (opcode_q == OP_PUT_PARTIAL) ? (wd_mask & size_mask)
                                                                    : size_mask;
                    end
                    a_fire = tlm_a_valid && tlm_a_ready;
                    if (a_fire) begin
                        a_cnt_d = a_cnt_q - CNT_W'(1);
                    end
                end

                // Responses may overtake the request stream; beats beyond the
                // expected count are swallowed and flagged as stray.
                if (d_cnt_q != '0) begin
                    tlm_d_ready = rsp_ready;
                    rsp_valid   = tlm_d_valid;
                    rsp_data    = tlm_d_data;
                    rsp_last    = (d_cnt_q == CNT_W'(1));
                    rsp_error   = tlm_d_denied || tlm_d_corrupt ||
                                  (tlm_d_source != SRC_ID) || (tlm_d_opcode != d_opcode_exp);
                    if (tlm_d_valid && rsp_ready) begin
                        d_cnt_d = d_cnt_q - CNT_W'(1);
                    end
                end else begin
                    tlm_d_ready = 1'b1;
                    stray_d     = tlm_d_valid;
                end

                if (a_cnt_d == '0 && d_cnt_d == '0) begin
                    state_d = IDLE;
                end else if (a_cnt_d == '0) begin
                    state_d = A_DONE_D_WAIT;
                end
            end

            ERR_RSP: begin
                rsp_valid   = 1'b1;
                rsp_error   = 1'b1;
                rsp_last    = 1'b1;
                tlm_d_ready = 1'b1;
                stray_d     = tlm_d_valid;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: only control state is reset; the command fields are qualified by
    // the state and are always rewritten before use.
    always_ff @(posedge tlm_clock_i) begin
        if (tlm_reset_i) begin
            state_q <= IDLE;
            a_cnt_q <= '0;
            d_cnt_q <= '0;
            stray_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_cnt_q <= a_cnt_d;
            d_cnt_q <= d_cnt_d;
            stray_q <= stray_d;
        end
    end

    always_ff @(posedge tlm_clock_i) begin
        opcode_q <= opcode_d;
        param_q  <= param_d;
        size_q   <= size_d;
        addr_q   <= addr_d;
    end

endmodule

// File: tb/tb_tl_initiator.sv
// Self-checking bench for tl_initiator: directed table, corner-case sequences
// and randomized transactions scored against a transaction-level model.
module tb_tl_initiator;

    localparam int TL_RS     = 4;
    localparam int TL_AW     = 16;
    localparam int SOURCE_ID = 0;
    localparam int MAX_SIZE  = 6;
    localparam logic [TL_RS-1:0] SRC = TL_RS'(SOURCE_ID);

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic             cmd_valid = 1'b0, cmd_ready;
    logic [2:0]       cmd_opcode = '0, cmd_param = '0;
    logic [3:0]       cmd_size = '0;
    logic [TL_AW-1:0] cmd_address = '0;
    logic             wd_valid = 1'b0, wd_ready;
    logic [31:0]      wd_data = '0;
    logic [3:0]       wd_mask = '0;
    logic             rsp_valid, rsp_ready = 1'b0;
    logic [31:0]      rsp_data;
    logic             rsp_last, rsp_error, busy, stray_o;
    logic [2:0]       tlm_a_opcode, tlm_a_param;
    logic [3:0]       tlm_a_size;
    logic [TL_RS-1:0] tlm_a_source;
    logic [TL_AW-1:0] tlm_a_address;
    logic [3:0]       tlm_a_mask;
    logic [31:0]      tlm_a_data;
    logic             tlm_a_corrupt, tlm_a_valid, tlm_a_ready = 1'b0;
    logic [2:0]       tlm_d_opcode = '0;
    logic [1:0]       tlm_d_param = '0;
    logic [3:0]       tlm_d_size = '0;
    logic [TL_RS-1:0] tlm_d_source = '0;
    logic             tlm_d_denied = 1'b0, tlm_d_corrupt = 1'b0, tlm_d_valid = 1'b0;
    logic [31:0]      tlm_d_data = '0;
    logic             tlm_d_ready;

    tl_initiator #(.TL_RS(TL_RS), .TL_AW(TL_AW), .SOURCE_ID(SOURCE_ID), .MAX_SIZE(MAX_SIZE)) dut (
        .tlm_clock_i(clk), .tlm_reset_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_param(cmd_param), .cmd_size(cmd_size), .cmd_address(cmd_address),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_mask(wd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_error(rsp_error), .busy(busy), .stray_o(stray_o),
        .tlm_a_opcode(tlm_a_opcode), .tlm_a_param(tlm_a_param), .tlm_a_size(tlm_a_size),
        .tlm_a_source(tlm_a_source), .tlm_a_address(tlm_a_address), .tlm_a_mask(tlm_a_mask),
        .tlm_a_data(tlm_a_data), .tlm_a_corrupt(tlm_a_corrupt), .tlm_a_valid(tlm_a_valid),
        .tlm_a_ready(tlm_a_ready),
        .tlm_d_opcode(tlm_d_opcode), .tlm_d_param(tlm_d_param), .tlm_d_size(tlm_d_size),
        .tlm_d_source(tlm_d_source), .tlm_d_denied(tlm_d_denied), .tlm_d_data(tlm_d_data),
        .tlm_d_corrupt(tlm_d_corrupt), .tlm_d_valid(tlm_d_valid), .tlm_d_ready(tlm_d_ready)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // mode: 0 random handshakes, 1 a_ready toggles, 2 everything always ready
    typedef struct {
        logic [2:0]  op;
        logic [2:0]  param;
        logic [3:0]  size;
        logic [15:0] addr;
        logic [3:0]  wmask;
        logic [31:0] dbase;
        int          mode;
        int          bad_src;
        bit          ill;
        int          na;
        int          nd;
        logic [3:0]  mask;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [2:0] op, input logic [2:0] param, input logic [3:0] size,
                                 input logic [15:0] addr, input logic [3:0] wmask,
                                 input logic [31:0] dbase, input int mode, input int bad_src,
                                 input bit ill, input int na, input int nd, input logic [3:0] mask);
        vec_t v;
        v.op = op; v.param = param; v.size = size; v.addr = addr; v.wmask = wmask;
        v.dbase = dbase; v.mode = mode; v.bad_src = bad_src;
        v.ill = ill; v.na = na; v.nd = nd; v.mask = mask;
        return v;
    endfunction

    // Reference model: TileLink rules written in terms of bytes and beats.
    function automatic bit m_illegal(input int op, input int sz, input int addr);
        int align = (sz < 2) ? (1 << sz) : 4;
        return (op > 4) || (sz > MAX_SIZE) || ((addr % align) != 0);
    endfunction

    function automatic int m_beats(input int sz);
        return (sz <= 2) ? 1 : (1 << (sz - 2));
    endfunction

    function automatic logic [3:0] m_mask(input int op, input int sz, input int addr,
                                          input logic [3:0] wmask);
        logic [3:0] m = '0;
        int first  = addr % 4;
        int nbytes = (sz < 2) ? (1 << sz) : 4;
        for (int lane = 0; lane < 4; lane++) begin
            m[lane] = (lane >= first) && (lane < first + nbytes);
        end
        return (op == 1) ? (m & wmask) : m;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cmd_valid = 1'b0; wd_valid = 1'b0; tlm_d_valid = 1'b0; rsp_ready = 1'b0; tlm_a_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] param, input logic [3:0] size,
                         input logic [15:0] addr);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opcode = op; cmd_param = param; cmd_size = size; cmd_address = addr;
        #1;
        check("cmd_ready", cmd_ready, 1);
    endtask

    task automatic run_txn(input vec_t v);
        logic [31:0] wdat [16];
        int          na = 0, nd = 0, wd_idx = 0, cyc = 0;
        bit          a_fire = 0, d_fire = 0, w_fire = 0, exp_err;
        bit          is_get = (v.op == 3'd4);
        logic [2:0]  d_op_exp = (v.op <= 3'd1) ? 3'd0 : 3'd1;
        logic [31:0] exp_data;
        foreach (wdat[i]) wdat[i] = $urandom;
        issue(v.op, v.param, v.size, v.addr);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (v.ill) begin
            rsp_ready = 1'b1;
            #1;
            check("err_rsp busy/valid/error/last/a_valid", {busy, rsp_valid, rsp_error, rsp_last, tlm_a_valid}, 5'b11110);
            check("err_rsp data", rsp_data, 0);
            @(negedge clk);
            rsp_ready = 1'b0;
            #1;
            check("err_done busy/valid", {busy, rsp_valid}, 2'b00);
        end else begin
            while (!(na == v.na && nd == v.nd) && cyc < 600) begin
                if (w_fire) wd_valid = 1'b0;
                if (d_fire) tlm_d_valid = 1'b0;
                case (v.mode)
                    1:       tlm_a_ready = (cyc % 2 == 0);
                    2:       tlm_a_ready = 1'b1;
                    default: tlm_a_ready = 1'($urandom_range(0, 1));
                endcase
                rsp_ready = (v.mode != 0) ? 1'b1 : 1'($urandom_range(0, 1));
                if (!is_get && !wd_valid && wd_idx < v.na && (v.mode != 0 || $urandom_range(0, 1) == 1)) begin
                    wd_valid = 1'b1; wd_data = wdat[wd_idx]; wd_mask = v.wmask;
                end
                if (!tlm_d_valid && na == v.na && nd < v.nd && (v.mode != 0 || $urandom_range(0, 1) == 1)) begin
                    tlm_d_valid   = 1'b1;
                    tlm_d_data    = (v.op <= 3'd1) ? 32'd0 : v.dbase + 32'(nd);
                    tlm_d_source  = (nd == v.bad_src) ? SRC + 1'b1 : SRC;
                    tlm_d_opcode  = d_op_exp;
                    tlm_d_size    = v.size;
                    tlm_d_denied  = 1'b0;
                    tlm_d_corrupt = 1'b0;
                    if (v.mode == 0) begin
                        tlm_d_denied  = ($urandom_range(0, 9) == 0);
                        tlm_d_corrupt = ($urandom_range(0, 9) == 0);
                        if ($urandom_range(0, 9) == 0) tlm_d_opcode = d_op_exp ^ 3'd1;
                    end
                end
                #1;
                if (cyc == 0) check("busy after accept", busy, 1);
                if (cyc == 0 && is_get) check("get a_valid next cycle", tlm_a_valid, 1);
                a_fire = tlm_a_valid && tlm_a_ready;
                w_fire = wd_valid && wd_ready;
                d_fire = tlm_d_valid && tlm_d_ready;
                if (a_fire || w_fire) check("wd/a handshake pairing", {a_fire, w_fire}, {1'b1, !is_get});
                if (a_fire) begin
                    check("a beat within count", na < v.na, 1);
                    check("a header", {tlm_a_opcode, tlm_a_param, tlm_a_size, tlm_a_address, tlm_a_source, tlm_a_corrupt},
                          {v.op, v.param, v.size, v.addr, SRC, 1'b0});
                    check("a mask", tlm_a_mask, v.mask);
                    check("a data", tlm_a_data, is_get ? 32'd0 : wdat[na % 16]);
                    na++;
                end
                if (w_fire) wd_idx++;
                if (d_fire) begin
                    exp_err  = tlm_d_denied || tlm_d_corrupt || (tlm_d_source != SRC) || (tlm_d_opcode != d_op_exp);
                    exp_data = (v.op <= 3'd1) ? 32'd0 : v.dbase + 32'(nd);
                    check("rsp valid/last/error", {rsp_valid, rsp_last, rsp_error}, {1'b1, nd == v.nd - 1, exp_err});
                    check("rsp data", rsp_data, exp_data);
                    nd++;
                end
                cyc++;
                if (!(na == v.na && nd == v.nd)) @(negedge clk);
            end
            check("txn completed within budget", (na == v.na) && (nd == v.nd), 1);
            @(negedge clk);
            wd_valid = 1'b0; tlm_d_valid = 1'b0; rsp_ready = 1'b0; tlm_a_ready = 1'b0;
            #1;
            check("idle after txn busy/a_valid", {busy, tlm_a_valid}, 2'b00);
            if (busy) do_reset();
        end
    endtask

    vec_t tbl [13];
    vec_t rv;
    int   sz;

    initial begin
        tbl[0]  = mkv(3'd4, 3'd0, 4'd2, 16'h0010, 4'hF, 32'hDEADBEEF, 2, -1, 0, 1,  1,  4'hF);
        tbl[1]  = mkv(3'd0, 3'd0, 4'd4, 16'h0100, 4'hF, 32'h0,        1, -1, 0, 4,  1,  4'hF);
        tbl[2]  = mkv(3'd1, 3'd0, 4'd0, 16'h0003, 4'hF, 32'h0,        2, -1, 0, 1,  1,  4'h8);
        tbl[3]  = mkv(3'd4, 3'd0, 4'd1, 16'h0002, 4'hF, 32'h12345678, 2, -1, 0, 1,  1,  4'hC);
        tbl[4]  = mkv(3'd4, 3'd0, 4'd3, 16'h0006, 4'hF, 32'h0,        2, -1, 1, 0,  0,  4'h0);
        tbl[5]  = mkv(3'd4, 3'd0, 4'd7, 16'h0000, 4'hF, 32'h0,        2, -1, 1, 0,  0,  4'h0);
        tbl[6]  = mkv(3'd3, 3'd2, 4'd3, 16'h0040, 4'hF, 32'hA0000000, 2,  1, 0, 2,  2,  4'hF);
        tbl[7]  = mkv(3'd2, 3'd4, 4'd2, 16'h0004, 4'hF, 32'h55AA0000, 1, -1, 0, 1,  1,  4'hF);
        tbl[8]  = mkv(3'd5, 3'd0, 4'd2, 16'h0000, 4'hF, 32'h0,        2, -1, 1, 0,  0,  4'h0);
        tbl[9]  = mkv(3'd0, 3'd0, 4'd6, 16'h0080, 4'hF, 32'h0,        0, -1, 0, 16, 1,  4'hF);
        tbl[10] = mkv(3'd4, 3'd0, 4'd6, 16'h0040, 4'hF, 32'hC0DE0000, 0, -1, 0, 1,  16, 4'hF);
        tbl[11] = mkv(3'd4, 3'd0, 4'd1, 16'h0001, 4'hF, 32'h0,        2, -1, 1, 0,  0,  4'h0);
        tbl[12] = mkv(3'd1, 3'd0, 4'd1, 16'h0002, 4'h6, 32'h0,        2, -1, 0, 1,  1,  4'h4);

        repeat (3) @(negedge clk);
        #1;
        check("reset outputs", {tlm_a_valid, wd_ready, rsp_valid, stray_o, busy, tlm_a_corrupt, cmd_ready}, 7'b0000001);
        rst = 1'b0;

        foreach (tbl[i]) run_txn(tbl[i]);

        // D beat while idle: consumed, dropped, one-cycle stray pulse.
        @(negedge clk);
        tlm_d_valid = 1'b1; tlm_d_opcode = 3'd1; tlm_d_source = SRC; tlm_d_data = 32'h1111_2222;
        #1;
        check("idle d_ready/rsp_valid", {tlm_d_ready, rsp_valid}, 2'b10);
        @(negedge clk);
        tlm_d_valid = 1'b0;
        #1;
        check("stray pulse in idle", stray_o, 1);
        @(negedge clk);
        #1;
        check("stray pulse ends", stray_o, 0);

        // Same-cycle last A beat and only D beat ends the transaction.
        issue(3'd0, 3'd0, 4'd2, 16'h0020);
        @(negedge clk);
        cmd_valid = 1'b0; wd_valid = 1'b1; wd_data = 32'hCAFE_F00D; wd_mask = 4'hF; tlm_a_ready = 1'b1;
        tlm_d_valid = 1'b1; tlm_d_opcode = 3'd0; tlm_d_source = SRC; tlm_d_data = 32'd0;
        tlm_d_denied = 1'b0; tlm_d_corrupt = 1'b0; rsp_ready = 1'b1;
        #1;
        check("same-cycle a_valid/rsp_valid/last/error", {tlm_a_valid, rsp_valid, rsp_last, rsp_error}, 4'b1110);
        @(negedge clk);
        wd_valid = 1'b0; tlm_d_valid = 1'b0; tlm_a_ready = 1'b0;
        #1;
        check("same-cycle idle busy/stray", {busy, stray_o}, 2'b00);

        // Early D ahead of the write burst, then a surplus D beat is stray.
        issue(3'd0, 3'd0, 4'd3, 16'h0030);
        @(negedge clk);
        cmd_valid = 1'b0; wd_valid = 1'b1; wd_data = 32'h0000_0001; tlm_a_ready = 1'b0;
        tlm_d_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        check("early d rsp valid/last/error", {rsp_valid, rsp_last, rsp_error}, 3'b110);
        @(negedge clk);
        tlm_a_ready = 1'b1;
        #1;
        check("surplus d dropped rsp_valid/d_ready", {rsp_valid, tlm_d_ready}, 2'b01);
        @(negedge clk);
        tlm_d_valid = 1'b0; wd_data = 32'h0000_0002;
        #1;
        check("surplus d stray/busy", {stray_o, busy}, 2'b11);
        @(negedge clk);
        wd_valid = 1'b0; tlm_a_ready = 1'b0; rsp_ready = 1'b0;
        #1;
        check("after early-d burst busy", busy, 0);

        // Reset in the middle of a four-beat write burst.
        issue(3'd0, 3'd0, 4'd4, 16'h0200);
        @(negedge clk);
        cmd_valid = 1'b0; wd_valid = 1'b1; tlm_a_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        wd_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; tlm_a_ready = 1'b0;
        #1;
        check("mid-burst reset a_valid/busy/cmd_ready/wd_ready/rsp_valid",
              {tlm_a_valid, busy, cmd_ready, wd_ready, rsp_valid}, 5'b00100);
        run_txn(mkv(3'd4, 3'd0, 4'd2, 16'h0010, 4'hF, 32'h600D_0000, 2, -1, 0, 1, 1, 4'hF));

        for (int t = 0; t < 40; t++) begin
            rv.op    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            sz       = ($urandom_range(0, 9) == 0) ? $urandom_range(7, 15) : $urandom_range(0, MAX_SIZE);
            rv.size  = 4'(sz);
            rv.addr  = 16'($urandom);
            if ($urandom_range(0, 4) != 0) rv.addr = rv.addr & ~16'(((sz < 2) ? (1 << sz) : 4) - 1);
            rv.param = 3'($urandom);
            rv.wmask = 4'($urandom);
            rv.dbase = $urandom;
            rv.mode  = 0;
            rv.bad_src = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
            rv.ill   = m_illegal(int'(rv.op), sz, int'(rv.addr));
            rv.na    = (rv.op == 3'd4) ? 1 : m_beats(sz);
            rv.nd    = (rv.op <= 3'd1) ? 1 : m_beats(sz);
            rv.mask  = m_mask(int'(rv.op), sz, int'(rv.addr), rv.wmask);
            run_txn(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tl_initiator.md
Name: tl_initiator

Overview:
- TileLink-UL/UH initiator (master) bridge from a simple command/stream interface onto the TL A/D channels.
- Peer of the team's TL SRAM responder; drives it for DMA, loaders and test masters.
- One transaction outstanding at a time. Supports Get, PutFullData, PutPartialData, ArithmeticData and LogicalData, single-beat and burst.

Parameters:
- TL_RS, 4, source field width.
- TL_AW, 16, address width.
- SOURCE_ID, 0, source value driven on A and expected on D.
- MAX_SIZE, 6, largest legal log2 byte size (64 B, 16 beats); must be 12 or less.

Ports:
- tlm_clock_i  in  1  clock
- tlm_reset_i  in  1  synchronous active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted
- cmd_opcode  in  3  TL A opcode (0,1,2,3,4)
- cmd_param  in  3  atomic param
- cmd_size  in  4  log2 bytes
- cmd_address  in  TL_AW  byte address
- wd_valid  in  1  write/atomic data beat valid
- wd_ready  out  1  data beat taken
- wd_data  in  32  beat data
- wd_mask  in  4  beat byte mask
- rsp_valid  out  1  response beat valid
- rsp_ready  in  1  response beat taken
- rsp_data  out  32  D data (0 for AccessAck/error)
- rsp_last  out  1  final beat of transaction
- rsp_error  out  1  denied/corrupt/protocol mismatch/illegal command
- busy  out  1  state != IDLE
- stray_o  out  1  one-cycle pulse: D beat received in IDLE
- tlm_a_opcode/param/size/source/address/mask/data/corrupt/valid  out  3/3/4/TL_RS/TL_AW/4/32/1/1  A channel
- tlm_a_ready  in  1  A ready
- tlm_d_opcode/param/size/source/denied/data/corrupt/valid  in  3/2/4/TL_RS/1/32/1/1  D channel
- tlm_d_ready  out  1  D ready

Behaviour:
- Reset (sync, any state): state=IDLE, both counters 0. tlm_a_valid=0, wd_ready=0, rsp_valid=0, stray_o=0, busy=0. tlm_a_corrupt is always 0.
- beats = 1 if size≤2, else 2^(size-2).
- Expected D beats: 1 for Put; beats for Get/atomic.
- Expected D opcode: AccessAck (0) for Put, AccessAckData (1) otherwise.
- States: IDLE, A_SEND, A_DONE_D_WAIT, ERR_RSP.
- IDLE:
  - cmd_ready=1 and tlm_d_ready=1.
  - On cmd_valid: latch the command and load a_cnt (A beats: 1 for Get, beats otherwise) and d_cnt (expected D beats).
  - Illegal commands go to ERR_RSP. Illegal means: opcode 5–7, size>MAX_SIZE, address not aligned to min(2^size,4), or size>2 with address[1:0]≠0 (covered by the alignment rule).
  - Legal commands go to A_SEND.
  - A D beat in IDLE is consumed and dropped; stray_o pulses.
- A_SEND:
  - A fields come from latched registers. Address and size stay constant across all burst beats.
  - size_mask: size 0 is one-hot at address[1:0]; size 1 is 4'b1100 if address[1], else 4'b0011; size≥2 is 4'b1111.
  - Get: tlm_a_valid=1, a_data=0, a_mask=size_mask. wd_ready=0.
  - Put/atomic: tlm_a_valid=wd_valid, wd_ready=tlm_a_ready, a_data=wd_data. a_mask = wd_mask&size_mask for PutPartial, size_mask otherwise.
  - Each A handshake decrements a_cnt. When it reaches 0, go to A_DONE_D_WAIT.
  - A fields must stay stable while valid&!ready.
- D acceptance (A_SEND and A_DONE_D_WAIT, for responders that answer early):
  - tlm_d_ready=rsp_ready; rsp_valid=tlm_d_valid, combinational pass-through. rsp_data=tlm_d_data.
  - rsp_last = (d_cnt==1).
  - rsp_error = d_denied | d_corrupt | d_source≠SOURCE_ID | d_opcode≠expected.
  - Each D handshake decrements d_cnt.
- Return to IDLE on the cycle where a_cnt==0 and d_cnt reaches 0. A same-cycle last A and last D is legal.
- A D beat arriving when d_cnt==0 in a non-IDLE state is consumed, dropped, and pulses stray_o.
- ERR_RSP: rsp_valid=1, rsp_error=1, rsp_last=1, rsp_data=0, no bus traffic. rsp_ready→IDLE.
- Latency: A valid the cycle after cmd acceptance; no added D-to-rsp latency.
- Counters are 5 bits and never wrap; underflow is prevented by the state guards.

Test Plan:
- 4 B Get at 0x0010, responder returns 0xDEADBEEF → one A beat (opcode 4, size 2, mask 1111); one rsp with data=0xDEADBEEF, last=1, error=0.
- PutFull size 4 at 0x0100, four wd beats with a_ready toggling every cycle → exactly 4 A beats, address 0x0100 on all, data in order; one rsp with last=1, data=0; busy deasserts the cycle after D.
- 1 B PutPartial at 0x0003, wd_mask=4'b1111 → a_mask=4'b1000; a 2 B Get at 0x0002 → a_mask=4'b1100.
- Get size 3 at 0x0006, then Get size 7 with MAX_SIZE=6 → each gives one error rsp with no A traffic, busy for 1 cycle with rsp_ready=1.
- Logical size 3 with D returning d_source=SOURCE_ID+1 on beat 2 → beat 2 carries rsp_error=1, rsp_last=1; a D beat injected in IDLE → stray_o=1 for one cycle.
- Reset asserted mid-burst (after 2 of 4 A beats) → next cycle tlm_a_valid=0, busy=0, cmd_ready=1; a fresh Get completes normally.
